inst_fetch_unit: RTL and testbench

- Instruction fetch stage directly downstream of the program counter.
- Holds the fetch address, which it initialises to 0 and loads from the PC/jump path on redirect.
- Issues word reads to a synchronous instruction memory with 1-cycle read latency, and buffers the returned words with their PCs in a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake.

---
 rtl/inst_fetch_unit.sv | 125 ++++++++++++
 tb/tb_inst_fetch_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: fetch address register, 1-cycle imem read issue, prefetch FIFO to decode.
// Optional `FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_bubbles counters.
module inst_fetch_unit #(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       perf_fetched,
  output logic [15:0]       perf_bubbles
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic              in_flight;
  logic [ADDR_W-1:0] fifo_pc   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic              pop;
  logic              push;
  logic              issue;
  logic [CNT_W-1:0]  occupancy;

  // Issue only when the slot reserved for the response is guaranteed free at push time.
  always_comb begin
    pop       = inst_valid & inst_ready;
    push      = in_flight & ~redirect_valid;
    occupancy = count + CNT_W'(in_flight);
    issue     = 1'b0;
    if (!rst && !redirect_valid) begin
      if (occupancy < CNT_W'(FIFO_DEPTH)) begin
        issue = 1'b1;
      end else if (occupancy == CNT_W'(FIFO_DEPTH) && pop) begin
        issue = 1'b1;
      end
    end
  end

  assign imem_en    = issue;
  assign imem_addr  = fetch_pc;
  assign inst_valid = (count != '0);
  assign inst_data  = fifo_data[rd_ptr];
  assign inst_pc    = fifo_pc[rd_ptr];

  // Redirect flushes the FIFO and drops the response arriving this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= '0;
      resp_pc   <= '0;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_data[i] <= '0;
      end
    end else if (redirect_valid) begin
      fetch_pc  <= redirect_pc;
      in_flight <= 1'b0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      if (issue) begin
        fetch_pc <= fetch_pc + ADDR_W'(1);
        resp_pc  <= fetch_pc;
      end
      in_flight <= issue;
      if (push) begin
        fifo_pc[wr_ptr]   <= resp_pc;
        fifo_data[wr_ptr] <= imem_rdata;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  push_when_full_a: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == CNT_W'(FIFO_DEPTH)));

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: delivered instructions and empty-head cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop && perf_fetched != 16'hFFFF) begin
        perf_fetched <= perf_fetched + 16'd1;
      end
      if (!inst_valid && perf_bubbles != 16'hFFFF) begin
        perf_bubbles <= perf_bubbles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomized self-checking bench for inst_fetch_unit against a stream-level reference model.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [31:0] imem_rdata = 32'hDEAD_BEEF;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [7:0]  inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_bubbles;
  int          m_fetched = 0;
  int          m_bubbles = 0;
`endif

  int          checks   = 0;
  int          failures = 0;

  // Reference model: next pc decode must see, next address to issue, cycles since fetch (re)start.
  logic [7:0]  exp_pc    = 8'h00;
  logic [7:0]  exp_issue = 8'h00;
  int          since     = 0;
  logic        rdy_d1    = 1'b0;
  logic        rdy_d2    = 1'b0;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  // Synchronous instruction memory with 1-cycle latency; garbage when not read.
  always @(posedge clk) begin
    imem_rdata <= imem_en ? word_of(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    #1;
    check("rst_imem_en",    32'(imem_en),    32'd0);
    check("rst_imem_addr",  32'(imem_addr),  32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data",  inst_data,       32'd0);
    check("rst_inst_pc",    32'(inst_pc),    32'd0);
`ifdef FETCH_PERF_CNT_EN
    check("rst_perf_fetched", 32'(perf_fetched), 32'd0);
    check("rst_perf_bubbles", 32'(perf_bubbles), 32'd0);
    m_fetched = 0;
    m_bubbles = 0;
`endif
    @(posedge clk);
    #2 rst = 1'b0;
    exp_pc    = 8'h00;
    exp_issue = 8'h00;
    since     = 0;
  endtask

  task automatic cycle(input logic rdy, input logic rv, input logic [7:0] rpc);
    @(negedge clk);
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
    check("inst_valid", 32'(inst_valid), 32'(since >= 2));
    if (inst_valid) begin
      check("inst_pc",   32'(inst_pc), 32'(exp_pc));
      check("inst_data", inst_data,    word_of(exp_pc));
    end
    if (rv) begin
      check("en_on_redirect", 32'(imem_en), 32'd0);
    end else if (since == 0) begin
      check("en_on_start", 32'(imem_en), 32'd1);
    end else if (!rdy && !rdy_d1 && !rdy_d2 && since >= 2) begin
      check("en_when_full", 32'(imem_en), 32'd0);
    end
    if (imem_en) begin
      check("imem_addr", 32'(imem_addr), 32'(exp_issue));
      exp_issue = exp_issue + 8'd1;
    end
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetched", 32'(perf_fetched), 32'((m_fetched > 65535) ? 65535 : m_fetched));
    check("perf_bubbles", 32'(perf_bubbles), 32'((m_bubbles > 65535) ? 65535 : m_bubbles));
    if (inst_valid && rdy) m_fetched++;
    if (!inst_valid) m_bubbles++;
`endif
    if (inst_valid && rdy) exp_pc = exp_pc + 8'd1;
    rdy_d2 = rdy_d1;
    rdy_d1 = rdy;
    if (rv) begin
      exp_pc    = rpc;
      exp_issue = rpc;
      since     = 0;
    end else if (since < 1000) begin
      since++;
    end
  endtask

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'h00;
    do_reset();
    // Streaming from reset
    repeat (8) cycle(1'b1, 1'b0, 8'h00);
    // Long stall fills the FIFO, then drain in order
    repeat (10) cycle(1'b0, 1'b0, 8'h00);
    repeat (6) cycle(1'b1, 1'b0, 8'h00);
    // Redirect while FIFO filling with a read in flight
    cycle(1'b0, 1'b1, 8'h40);
    repeat (8) cycle(1'b1, 1'b0, 8'h00);
    // Redirect near the top of the address space: wrap
    cycle(1'b1, 1'b1, 8'hFE);
    repeat (8) cycle(1'b1, 1'b0, 8'h00);
    // Reset mid-stream with a read in flight
    repeat (3) cycle(1'b1, 1'b0, 8'h00);
    do_reset();
    repeat (8) cycle(1'b1, 1'b0, 8'h00);
    // Back-to-back redirects: last one wins
    cycle(1'b1, 1'b1, 8'h10);
    cycle(1'b0, 1'b1, 8'h20);
    repeat (6) cycle(1'b1, 1'b0, 8'h00);
    // Pops interleaved with idle cycles
    repeat (5) begin
      cycle(1'b1, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
    end
    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 29) == 0),
            8'($urandom));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
